hourglass_pair_timer: RTL and testbench

- Parametrised successor of the two-hourglass interval model. Tracks the sand in the top half of each glass and drains it one event per clock.
- Adds what the fixed 4/7 model lacks: a start handshake with a run state machine, configurable glass capacities and widths, and a configurable unreachable-interval mask.
- Also adds stall detection, an event counter and an asynchronous reset.
- Used as the generic puzzle instance for parametrised model-checking runs.

---
 rtl/hourglass_pair_timer.sv | 192 +++++++++++++++++++
 tb/tb_hourglass_pair_timer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hourglass_pair_timer.sv
// hourglass_pair_timer
// Two-hourglass interval measurer. Each glass tracks the sand left in its top
// half. Every clock in RUN, the smaller nonzero top drains completely (one
// "event"), and that amount is subtracted from the interval still to measure.
// Turn requests are registered and flip their glass one cycle later.
// The failed and stalled flags are combinational views of the registered state.
module hourglass_pair_timer #(
    parameter int          W            = 8,
    parameter int          CAPW         = 3,
    parameter int          SMALL        = 4,
    parameter int          LARGE        = 7,
    parameter int          EVW          = 4,
    parameter logic [31:0] UNREACH_MASK = 32'h0000_006E
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [W-1:0]    start_time,
    input  logic            turn_small,
    input  logic            turn_large,
    output logic            busy,
    output logic            done,
    output logic            failed,
    output logic            stalled,
    output logic [W-1:0]    remaining,
    output logic [CAPW-1:0] small_top,
    output logic [CAPW-1:0] large_top,
    output logic [EVW-1:0]  event_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Capacities in top-half width. The flip computes capacity - top, which
    // cannot underflow because a top never exceeds its capacity.
    localparam logic [CAPW-1:0] SMALL_CAP = CAPW'(SMALL);
    localparam logic [CAPW-1:0] LARGE_CAP = CAPW'(LARGE);
    localparam logic [EVW-1:0]  EV_MAX    = {EVW{1'b1}};
    localparam logic [EVW-1:0]  EV_ONE    = EVW'(1);

    // Wide enough to compare remaining against 32 even when W is narrow.
    localparam int RW = (W > 6) ? W : 6;

    // Registered state
    state_t          state_q, state_d;
    logic [W-1:0]    remaining_q, remaining_d;
    logic [CAPW-1:0] small_top_q, small_top_d;
    logic [CAPW-1:0] large_top_q, large_top_d;
    logic [EVW-1:0]  event_count_q, event_count_d;
    logic            ts_q, ts_d;
    logic            tl_q, tl_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Datapath intermediates
    logic [CAPW-1:0] step;
    logic [W-1:0]    step_w;
    logic            step_nz;
    logic            can_drain;
    logic [W-1:0]    rem_after;
    logic [CAPW-1:0] small_after;
    logic [CAPW-1:0] large_after;
    logic [RW-1:0]   rem_ext;
    logic            rem_in_mask;
    logic            run_now;

    // Drain amount: the smaller nonzero top, or zero when both glasses are empty.
    always_comb begin
        step = '0;
        if (small_top_q == '0) begin
            step = large_top_q;
        end else if (large_top_q == '0) begin
            step = small_top_q;
        end else if (small_top_q < large_top_q) begin
            step = small_top_q;
        end else begin
            step = large_top_q;
        end
    end

    assign step_w    = W'(step);
    assign step_nz   = (step != '0);
    assign can_drain = step_nz && (remaining_q >= step_w);
    assign run_now   = (state_q == ST_RUN);

    // Tops and remaining after a possible drain, before any flip.
    always_comb begin
        rem_after   = remaining_q;
        small_after = small_top_q;
        large_after = large_top_q;
        if (can_drain) begin
            rem_after = remaining_q - step_w;
            if (small_top_q != '0) begin
                small_after = small_top_q - step;
            end
            if (large_top_q != '0) begin
                large_after = large_top_q - step;
            end
        end
    end

    // Next-state logic: start wins from any state; only RUN advances the glasses.
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        small_top_d   = small_top_q;
        large_top_d   = large_top_q;
        event_count_d = event_count_q;
        ts_d          = ts_q;
        tl_d          = tl_q;

        if (start) begin
            remaining_d   = start_time;
            small_top_d   = '0;
            large_top_d   = '0;
            event_count_d = '0;
            ts_d          = 1'b0;
            tl_d          = 1'b0;
            state_d       = (start_time == '0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_RUN) begin
            // Requests sampled now are what flips the glasses next cycle.
            ts_d = turn_small;
            tl_d = turn_large;

            remaining_d = rem_after;
            if (can_drain && (event_count_q != EV_MAX)) begin
                event_count_d = event_count_q + EV_ONE;
            end

            // Flip is applied after the drain, using last cycle's requests.
            small_top_d = ts_q ? (SMALL_CAP - small_after) : small_after;
            large_top_d = tl_q ? (LARGE_CAP - large_after) : large_after;

            if (rem_after == '0) begin
                state_d = ST_DONE;
            end
        end
    end

    // Status flags are registered from the next state so they track state_q exactly.
    always_comb begin
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset aborts any run at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            small_top_q   <= '0;
            large_top_q   <= '0;
            event_count_q <= '0;
            ts_q          <= 1'b0;
            tl_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            small_top_q   <= small_top_d;
            large_top_q   <= large_top_d;
            event_count_q <= event_count_d;
            ts_q          <= ts_d;
            tl_q          <= tl_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Unmeasurable-interval lookup, limited to intervals below 32.
    always_comb begin
        rem_ext     = RW'(remaining_q);
        rem_in_mask = 1'b0;
        if (rem_ext < RW'(32)) begin
            rem_in_mask = UNREACH_MASK[rem_ext[4:0]];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign failed      = run_now && rem_in_mask;
    assign stalled     = run_now && step_nz && (remaining_q < step_w);
    assign remaining   = remaining_q;
    assign small_top   = small_top_q;
    assign large_top   = large_top_q;
    assign event_count = event_count_q;

endmodule

// File: tb/tb_hourglass_pair_timer.sv
// Testbench for hourglass_pair_timer: directed scenarios plus random traffic,
// each cycle compared against an integer-level model of the glasses.
module tb_hourglass_pair_timer;

    localparam int          W     = 8;
    localparam int          CAPW  = 3;
    localparam int          SMALL = 4;
    localparam int          LARGE = 7;
    localparam int          EVW   = 2;
    localparam logic [31:0] MASK  = 32'h0000_006E;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    start_time = '0;
    logic            turn_small = 1'b0;
    logic            turn_large = 1'b0;
    logic            busy, done, failed, stalled;
    logic [W-1:0]    remaining;
    logic [CAPW-1:0] small_top, large_top;
    logic [EVW-1:0]  event_count;

    hourglass_pair_timer #(
        .W(W), .CAPW(CAPW), .SMALL(SMALL), .LARGE(LARGE), .EVW(EVW), .UNREACH_MASK(MASK)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .start_time(start_time),
        .turn_small(turn_small), .turn_large(turn_large),
        .busy(busy), .done(done), .failed(failed), .stalled(stalled),
        .remaining(remaining), .small_top(small_top), .large_top(large_top),
        .event_count(event_count)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: 0 idle, 1 running, 2 finished; sand amounts as integers.
    int m_state, m_rem, m_s, m_l, m_ev;
    bit m_ts, m_tl;

    function automatic int m_step();
        if (m_s == 0 && m_l == 0) return 0;
        if (m_s == 0) return m_l;
        if (m_l == 0) return m_s;
        return (m_s < m_l) ? m_s : m_l;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_rem = 0; m_s = 0; m_l = 0; m_ev = 0; m_ts = 0; m_tl = 0;
    endfunction

    function automatic void model_edge(bit s, int st, bit a, bit b);
        int stp;
        if (s) begin
            m_rem = st; m_s = 0; m_l = 0; m_ev = 0; m_ts = 0; m_tl = 0;
            m_state = (st == 0) ? 2 : 1;
            return;
        end
        if (m_state != 1) return;
        stp = m_step();
        if (stp != 0 && m_rem >= stp) begin
            m_rem -= stp;
            if (m_s > 0) m_s -= stp;
            if (m_l > 0) m_l -= stp;
            if (m_ev < (1 << EVW) - 1) m_ev++;
        end
        if (m_ts) m_s = SMALL - m_s;
        if (m_tl) m_l = LARGE - m_l;
        m_ts = a;
        m_tl = b;
        if (m_rem == 0) m_state = 2;
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [31:0] mk;
        int  stp;
        bit  run, f, stl;
        mk  = MASK;
        stp = m_step();
        run = (m_state == 1);
        f   = run && (m_rem < 32) && mk[m_rem];
        stl = run && (stp != 0) && (m_rem < stp);
        return {run, m_state == 2, f, stl, 8'(m_rem), 3'(m_s), 3'(m_l), 2'(m_ev)};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {busy, done, failed, stalled, remaining, small_top, large_top, event_count};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
    task automatic cycle(input bit s, input int st, input bit a, input bit b);
        start = s; start_time = 8'(st); turn_small = a; turn_large = b;
        @(posedge clock);
        model_edge(s, st, a, b);
        #1;
        start = 1'b0; turn_small = 1'b0; turn_large = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        n_cmp++;
        if (obs_vec() !== 20'h0) begin
            n_fail++; $display("FAIL reset_outputs got %h want %h", obs_vec(), 20'h0);
        end
        #1 reset_n = 1'b1;
        cycle(0, 0, 1, 1);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL idle_hold got %h want %h", obs_vec(), exp_vec());
        end
        $display("reset: outputs %h", obs_vec());
    endtask

    task automatic test_small4();
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 4, i == 1, 0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL small4 c%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({done, busy, remaining, event_count} !== {1'b1, 1'b0, 8'd0, 2'd1}) begin
            n_fail++; $display("FAIL small4_end got d%b b%b r%0d e%0d want d1 b0 r0 e1",
                               done, busy, remaining, event_count);
        end
        $display("small4: rem=%0d ev=%0d done=%b", remaining, event_count, done);
    endtask

    task automatic test_large7();
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 7, 0, i == 1);
            n_cmp++;
            if (obs_vec() !== exp_vec() || failed !== 1'b0) begin
                n_fail++; $display("FAIL large7 c%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 2) begin
                n_cmp++;
                if (large_top !== 3'd7) begin
                    n_fail++; $display("FAIL large7_top got %0d want 7", large_top);
                end
            end
        end
        n_cmp++;
        if ({done, remaining, event_count} !== {1'b1, 8'd0, 2'd1}) begin
            n_fail++; $display("FAIL large7_end got d%b r%0d e%0d want d1 r0 e1",
                               done, remaining, event_count);
        end
        $display("large7: rem=%0d ev=%0d done=%b", remaining, event_count, done);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, 3, 0, i == 1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stall c%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({busy, stalled, failed, event_count, remaining, large_top} !==
            {1'b1, 1'b1, 1'b1, 2'd0, 8'd3, 3'd7}) begin
            n_fail++; $display("FAIL stall_end got b%b s%b f%b e%0d r%0d l%0d want b1 s1 f1 e0 r3 l7",
                               busy, stalled, failed, event_count, remaining, large_top);
        end
        $display("stall: rem=%0d large=%0d stalled=%b failed=%b", remaining, large_top, stalled, failed);
    endtask

    task automatic test_combined();
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, 8, i == 1 || i == 2, i == 1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL combo c%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 3) begin
                n_cmp++;
                if ({remaining, small_top, large_top} !== {8'd4, 3'd4, 3'd3}) begin
                    n_fail++; $display("FAIL combo_ev1 got r%0d s%0d l%0d want r4 s4 l3",
                                       remaining, small_top, large_top);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if ({remaining, small_top, large_top} !== {8'd1, 3'd1, 3'd0}) begin
                    n_fail++; $display("FAIL combo_ev2 got r%0d s%0d l%0d want r1 s1 l0",
                                       remaining, small_top, large_top);
                end
            end
        end
        n_cmp++;
        if ({done, remaining, event_count} !== {1'b1, 8'd0, 2'd3}) begin
            n_fail++; $display("FAIL combo_end got d%b r%0d e%0d want d1 r0 e3",
                               done, remaining, event_count);
        end
        $display("combined: rem=%0d ev=%0d done=%b", remaining, event_count, done);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cycle(i == 0, 9, i == 1, 0);
        n_cmp++;
        if ({busy, remaining} !== {1'b1, 8'd5}) begin
            n_fail++; $display("FAIL areset_pre got b%b r%0d want b1 r5", busy, remaining);
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (obs_vec() !== 20'h0) begin
            n_fail++; $display("FAIL areset_now got %h want %h", obs_vec(), 20'h0);
        end
        #1 reset_n = 1'b1;
        cycle(0, 0, 1, 0);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL areset_idle got %h want %h", obs_vec(), exp_vec());
        end
        $display("async_reset: outputs %h", obs_vec());
    endtask

    task automatic test_restart();
        for (int i = 0; i < 4; i++) cycle(i == 0, 9, i == 1, 0);
        cycle(1, 6, 1, 1);
        n_cmp++;
        if (obs_vec() !== exp_vec() ||
            {busy, remaining, event_count, small_top, large_top} !== {1'b1, 8'd6, 2'd0, 3'd0, 3'd0}) begin
            n_fail++; $display("FAIL restart got %h want %h", obs_vec(), exp_vec());
        end
        $display("restart: rem=%0d ev=%0d", remaining, event_count);
    endtask

    task automatic test_zero();
        cycle(1, 0, 0, 0);
        n_cmp++;
        if ({done, busy, event_count, remaining} !== {1'b1, 1'b0, 2'd0, 8'd0}) begin
            n_fail++; $display("FAIL zero got d%b b%b e%0d want d1 b0 e0", done, busy, event_count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL zero_hold c%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        $display("zero: done=%b ev=%0d", done, event_count);
    endtask

    task automatic test_saturation();
        cycle(1, 200, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 1, 0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL sat c%0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({busy, event_count, remaining} !== {1'b1, 2'd3, 8'd160}) begin
            n_fail++; $display("FAIL sat_end got b%b e%0d r%0d want b1 e3 r160",
                               busy, event_count, remaining);
        end
        $display("saturation: ev=%0d rem=%0d", event_count, remaining);
    endtask

    task automatic test_random();
        int r, errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 63));
            cycle(r < 4, int'($urandom_range(0, 30)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; errs++;
                $display("FAIL random c%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (r == 63) begin
                #2 reset_n = 1'b0;
                #1;
                model_reset();
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++; errs++;
                    $display("FAIL random_reset c%0d got %h want %h", i, obs_vec(), exp_vec());
                end
                #1 reset_n = 1'b1;
            end
        end
        $display("random: 400 cycles, %0d errors", errs);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_small4();
        test_large7();
        test_stall();
        test_combined();
        test_async_reset();
        test_restart();
        test_zero();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
